operand_stack: RTL
==================

OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 WIDTH, 64, data width of each stack entry; legal values 32 or 64.
REQ-002 DEPTH, 16, number of stack entries; any power of two from 2 to 256.
REQ-003 USE_64B, 1, enables i64 operands; WIDTH SHALL be 64 when set.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 op  input  3  operation: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 ADD, 5 SUB; codes 6 and 7 are illegal.
REQ-007 op_valid  input  1  op is presented this cycle.
REQ-008 op_ready  output  1  the block accepts op this cycle.
REQ-009 push_data  input  WIDTH  operand for PUSH.
REQ-010 push_type  input  2  operand type for PUSH, encoded with the core type macros (i32, i64, f32, f64).
REQ-011 result  output  WIDTH  top-of-stack value; zero when the stack is empty.
REQ-012 result_type  output  2  top-of-stack type; i32 encoding when the stack is empty.
REQ-013 result_empty  output  1  stack holds no entries.
REQ-014 depth  output  $clog2(DEPTH+1)  current entry count.
REQ-015 trap  output  4  0 none, 1 underflow, 2 overflow, 3 type mismatch, 4 unsupported type, 5 illegal op.

Function
REQ-016 An op SHALL be accepted only on a cycle where op_valid and op_ready are both 1; any other op_valid is ignored with no state change.
REQ-017 The FSM SHALL have the states IDLE, EXEC and TRAP; op_ready SHALL be 1 only in IDLE.
REQ-018 PUSH, POP, DUP and NOP SHALL complete in IDLE; result, result_type, result_empty and depth SHALL reflect the new state on the edge that accepts the op.
REQ-019 ADD/SUB accepted in IDLE SHALL move the FSM to EXEC for exactly one cycle.
REQ-020 In EXEC, the block SHALL pop the two top entries, compute second-from-top op top, push the result, and return to IDLE; the result is visible 2 edges after acceptance.
REQ-021 SUB SHALL compute next-to-top minus top (push 3, push 2, SUB gives 1).
REQ-022 i32 arithmetic SHALL wrap modulo 2^32, with bits WIDTH-1:32 of the result forced to zero.
REQ-023 i64 arithmetic SHALL wrap modulo 2^64.
REQ-024 ADD/SUB on f32 or f64 operands SHALL raise trap 4.
REQ-025 PUSH with an i64/f64 push_type while USE_64B=0 SHALL raise trap 4.
REQ-026 A PUSH of an i32 operand SHALL store push_data[31:0] zero-extended.
REQ-027 POP on an empty stack, DUP on an empty stack, or ADD/SUB with depth<2 SHALL raise trap 1.
REQ-028 PUSH or DUP with depth==DEPTH SHALL raise trap 2.
REQ-029 An illegal op SHALL raise trap 5.
REQ-030 A trapping op SHALL leave the stack contents and depth unchanged.
REQ-031 Any nonzero trap SHALL move the FSM to TRAP; trap is sticky, op_ready=0, and all ops are ignored until reset.
REQ-032 The stack pointer SHALL never wrap; the overflow and underflow checks take precedence over any write.

Reset
REQ-033 reset=0 at a rising edge SHALL set: FSM to IDLE, depth 0, result 0, result_type i32, result_empty 1, trap 0, op_ready 1 on the following cycle.
REQ-034 Reset asserted in EXEC or TRAP SHALL abort the operation and discard all entries; stack RAM contents need not be cleared.

Configuration
REQ-035 The macro OPERAND_STACK_TYPE_CHECK_EN SHALL control operand type checking for ADD/SUB.
REQ-036 With OPERAND_STACK_TYPE_CHECK_EN defined, ADD/SUB on operands of differing type SHALL raise trap 3.
REQ-037 Without OPERAND_STACK_TYPE_CHECK_EN, mismatched operands SHALL be computed at the width of the top operand's type, and that type SHALL be pushed; trap 3 is never raised.

Verification
REQ-038 PUSH i32 3, PUSH i32 2, SUB -> two edges later: result=1, result_type=i32, result_empty=0, depth=1, trap=0.
REQ-039 PUSH i32 0, PUSH i32 1, SUB -> result=0x00000000FFFFFFFF, type i32; the same sequence with i64 operands -> result=0xFFFFFFFFFFFFFFFF.
REQ-040 From reset, POP -> trap=1, result_empty=1, op_ready=0; a later PUSH is ignored and depth stays 0.
REQ-041 DEPTH+1 consecutive PUSH i32 -> trap=2 on the last one, depth=DEPTH, result = the DEPTH-th pushed value.
REQ-042 PUSH i32 5, PUSH i64 5, ADD -> trap=3 with OPERAND_STACK_TYPE_CHECK_EN; without it: result=10, result_type=i64.
REQ-043 Reset driven low during the EXEC cycle of a SUB -> next cycle: depth=0, result_empty=1, trap=0, op_ready=1.

Source files
------------

// File: rtl/operand_stack.sv
// operand_stack: typed LIFO operand stack with PUSH/POP/DUP/ADD/SUB.
// Optional build macro OPERAND_STACK_TYPE_CHECK_EN: when defined, ADD/SUB on
// operands of differing type trap with code 3; otherwise the top operand's
// type decides the arithmetic width and the pushed result type.
module operand_stack #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned DEPTH   = 16,
  parameter bit          USE_64B = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 op,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [WIDTH-1:0]           push_data,
  input  logic [1:0]                 push_type,
  output logic [WIDTH-1:0]           result,
  output logic [1:0]                 result_type,
  output logic                       result_empty,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic [3:0]                 trap
);

  localparam int unsigned SW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;

  localparam logic [1:0] T_I32 = 2'd0;
  localparam logic [1:0] T_I64 = 2'd1;
  localparam logic [1:0] T_F32 = 2'd2;
  localparam logic [1:0] T_F64 = 2'd3;

  localparam logic [3:0] TR_NONE = 4'd0;
  localparam logic [3:0] TR_UND  = 4'd1;
  localparam logic [3:0] TR_OVF  = 4'd2;
  localparam logic [3:0] TR_MIS  = 4'd3;
  localparam logic [3:0] TR_UNS  = 4'd4;
  localparam logic [3:0] TR_ILL  = 4'd5;

  localparam logic [WIDTH-1:0] MASK32 = WIDTH'(64'h0000_0000_FFFF_FFFF);

  typedef enum logic [1:0] {IDLE, EXEC, TRAP} state_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    sp, sp_nxt;
  logic [3:0]       trap_q, trap_nxt;
  logic             is_sub;

  logic [WIDTH-1:0] mem  [DEPTH];
  logic [1:0]       tmem [DEPTH];

  logic             we;
  logic [AW-1:0]    widx;
  logic [WIDTH-1:0] wdata;
  logic [1:0]       wtype;

  logic [AW-1:0]    top_idx, sec_idx, push_idx;
  logic [WIDTH-1:0] top_val, sec_val, arith_full, arith_res, push_ext;
  logic [1:0]       top_type, sec_type;
  logic             is_empty, is_full, is_float, is_wide_push;

  assign top_idx  = AW'(sp - SW'(1));
  assign sec_idx  = AW'(sp - SW'(2));
  assign push_idx = AW'(sp);
  assign top_val  = mem[top_idx];
  assign sec_val  = mem[sec_idx];
  assign top_type = tmem[top_idx];
  assign sec_type = tmem[sec_idx];
  assign is_empty = (sp == '0);
  assign is_full  = (sp == SW'(DEPTH));

  assign is_float     = (top_type == T_F32) || (top_type == T_F64) ||
                        (sec_type == T_F32) || (sec_type == T_F64);
  assign is_wide_push = (push_type == T_I64) || (push_type == T_F64);
  assign push_ext     = (push_type == T_I32) ? (push_data & MASK32) : push_data;

  // Arithmetic runs at full width; an i32 top operand truncates to 32 bits
  assign arith_full = is_sub ? (sec_val - top_val) : (sec_val + top_val);
  assign arith_res  = (top_type == T_I32) ? (arith_full & MASK32) : arith_full;

  assign result       = is_empty ? '0 : top_val;
  assign result_type  = is_empty ? T_I32 : top_type;
  assign result_empty = is_empty;
  assign depth        = sp;
  assign trap         = trap_q;

  // Control state, stack pointer and sticky trap register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      sp     <= '0;
      trap_q <= TR_NONE;
      is_sub <= 1'b0;
    end else begin
      state  <= state_nxt;
      sp     <= sp_nxt;
      trap_q <= trap_nxt;
      if (state == IDLE && op_valid) begin
        is_sub <= (op == OP_SUB);
      end
    end
  end

  // Stack storage; contents survive reset, only the pointer is cleared
  always_ff @(posedge clk) begin
    if (reset && we) begin
      mem[widx]  <= wdata;
      tmem[widx] <= wtype;
    end
  end

  // Next-state, trap detection and stack write control
  always_comb begin
    state_nxt = state;
    sp_nxt    = sp;
    trap_nxt  = trap_q;
    we        = 1'b0;
    widx      = push_idx;
    wdata     = push_ext;
    wtype     = push_type;
    op_ready  = (state == IDLE);
    case (state)
      IDLE: begin
        if (op_valid) begin
          case (op)
            OP_NOP: ;
            OP_PUSH: begin
              if (is_full) begin
                trap_nxt = TR_OVF;
              end else if (!USE_64B && is_wide_push) begin
                trap_nxt = TR_UNS;
              end else begin
                we     = 1'b1;
                sp_nxt = sp + SW'(1);
              end
            end
            OP_POP: begin
              if (is_empty) trap_nxt = TR_UND;
              else          sp_nxt   = sp - SW'(1);
            end
            OP_DUP: begin
              if (is_empty) begin
                trap_nxt = TR_UND;
              end else if (is_full) begin
                trap_nxt = TR_OVF;
              end else begin
                we     = 1'b1;
                wdata  = top_val;
                wtype  = top_type;
                sp_nxt = sp + SW'(1);
              end
            end
            OP_ADD, OP_SUB: begin
              if (sp < SW'(2)) begin
                trap_nxt = TR_UND;
              end else if (is_float) begin
                trap_nxt = TR_UNS;
`ifdef OPERAND_STACK_TYPE_CHECK_EN
              end else if (top_type != sec_type) begin
                trap_nxt = TR_MIS;
`endif
              end else begin
                state_nxt = EXEC;
              end
            end
            default: trap_nxt = TR_ILL;
          endcase
          if (trap_nxt != TR_NONE) state_nxt = TRAP;
        end
      end
      // Two pops and a push collapse into one write over the second entry
      EXEC: begin
        we        = 1'b1;
        widx      = sec_idx;
        wdata     = arith_res;
        wtype     = top_type;
        sp_nxt    = sp - SW'(1);
        state_nxt = IDLE;
      end
      TRAP: ;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
